// File: rtl/audio_stereo_mixer.sv
// Stereo post-processor between the core's SOUND_L/SOUND_R and the DACs:
// crossfeed, optional DC blocker, anti-pop gain ramp, with saturation throughout.
module audio_stereo_mixer #(
  parameter int W         = 16,
  parameter int DCB_EN    = 1,
  parameter int DCB_SHIFT = 10,
  parameter int RAMP_STEP = 1
) (
  input  logic         clk_i,
  input  logic         res_n_i,
  input  logic         ce_i,
  input  logic [1:0]   mix_i,
  input  logic         mute_i,
  input  logic [W-1:0] left_i,
  input  logic [W-1:0] right_i,
  output logic [W-1:0] left_o,
  output logic [W-1:0] right_o,
  output logic         valid_o
);

  // Wide enough for the gain product (W + 9-bit gain + sign) and every intermediate sum.
  localparam int XW = W + 10;
  localparam logic signed [XW-1:0] SAT_HI = {{(XW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [XW-1:0] SAT_LO = {{(XW-W+1){1'b1}}, {(W-1){1'b0}}};
  localparam logic [W-1:0]         MID    = {1'b1, {(W-1){1'b0}}};
  localparam logic [8:0]           GMAX   = 9'd256;
  localparam logic [9:0]           STEP   = 10'(RAMP_STEP);

  function automatic logic signed [XW-1:0] sx(input logic signed [W-1:0] v);
    return {{(XW-W){v[W-1]}}, v};
  endfunction

  function automatic logic signed [W-1:0] sat(input logic signed [XW-1:0] v);
    if (v > SAT_HI)      return SAT_HI[W-1:0];
    else if (v < SAT_LO) return SAT_LO[W-1:0];
    else                 return v[W-1:0];
  endfunction

  // Offset-binary <-> two's complement is a single MSB flip in both directions.
  function automatic logic [W-1:0] flip(input logic [W-1:0] v);
    return {~v[W-1], v[W-2:0]};
  endfunction

  logic                vld_p1_q, vld_p2_q, vld_p3_q, vld_p4_q;
  logic signed [W-1:0] l_p1_q, r_p1_q, l_p2_q, r_p2_q, l_p3_q, r_p3_q;
  logic [1:0]          mix_p1_q;
  logic signed [W-1:0] xl_prev_q, xr_prev_q, yl_prev_q, yr_prev_q;
  logic [8:0]          gain_q, gain_d;
  logic [W-1:0]        left_q, right_q;

  logic signed [XW-1:0] l_p2_x, r_p2_x, d_p2, sh_p2, l_p2_d, r_p2_d;
  logic signed [XW-1:0] yl_p3_x, yr_p3_x;
  logic signed [W-1:0]  yl_p3_d, yr_p3_d;
  logic signed [XW-1:0] gain_x, pl_p4_x, pr_p4_x;
  logic [9:0]           gsum;

  // ---- S1: capture, convert to signed, latch mix with the sample
  always_ff @(posedge clk_i) begin
    if (ce_i) begin
      l_p1_q   <= flip(left_i);
      r_p1_q   <= flip(right_i);
      mix_p1_q <= mix_i;
    end
  end

  // ---- S2: crossfeed; mix 3 averages both channels with floor rounding
  always_comb begin
    l_p2_x = sx(l_p1_q);
    r_p2_x = sx(r_p1_q);
    d_p2   = r_p2_x - l_p2_x;
    case (mix_p1_q)
      2'd1:    sh_p2 = d_p2 >>> 3;
      2'd2:    sh_p2 = d_p2 >>> 2;
      2'd3:    sh_p2 = d_p2 >>> 1;
      default: sh_p2 = '0;
    endcase
    l_p2_d = l_p2_x + sh_p2;
    r_p2_d = r_p2_x - sh_p2;
    if (mix_p1_q == 2'd3) begin
      l_p2_d = (l_p2_x + r_p2_x) >>> 1;
      r_p2_d = l_p2_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (vld_p1_q) begin
      l_p2_q <= sat(l_p2_d);
      r_p2_q <= sat(r_p2_d);
    end
  end

  // ---- S3: DC blocker, state kept saturated so a full-scale step clamps instead of wrapping
  always_comb begin
    yl_p3_x = sx(l_p2_q) - sx(xl_prev_q) + sx(yl_prev_q) - (sx(yl_prev_q) >>> DCB_SHIFT);
    yr_p3_x = sx(r_p2_q) - sx(xr_prev_q) + sx(yr_prev_q) - (sx(yr_prev_q) >>> DCB_SHIFT);
    yl_p3_d = sat(yl_p3_x);
    yr_p3_d = sat(yr_p3_x);
  end

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      xl_prev_q <= '0;
      xr_prev_q <= '0;
      yl_prev_q <= '0;
      yr_prev_q <= '0;
    end else if (vld_p2_q) begin
      xl_prev_q <= l_p2_q;
      xr_prev_q <= r_p2_q;
      yl_prev_q <= yl_p3_d;
      yr_prev_q <= yr_p3_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (vld_p2_q) begin
      l_p3_q <= (DCB_EN != 0) ? yl_p3_d : l_p2_q;
      r_p3_q <= (DCB_EN != 0) ? yr_p3_d : r_p2_q;
    end
  end

  // ---- S4: gain ramp; the gain moves one step after each sample that used it
  always_comb begin
    gain_x  = {{(XW-9){1'b0}}, gain_q};
    pl_p4_x = (sx(l_p3_q) * gain_x) >>> 8;
    pr_p4_x = (sx(r_p3_q) * gain_x) >>> 8;
    gsum    = {1'b0, gain_q} + STEP;
    if (mute_i) gain_d = ({1'b0, gain_q} > STEP) ? (gain_q - STEP[8:0]) : 9'd0;
    else        gain_d = (gsum >= {1'b0, GMAX}) ? GMAX : gsum[8:0];
  end

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
      vld_p4_q <= 1'b0;
      gain_q   <= '0;
      left_q   <= MID;
      right_q  <= MID;
    end else begin
      vld_p1_q <= ce_i;
      vld_p2_q <= vld_p1_q;
      vld_p3_q <= vld_p2_q;
      vld_p4_q <= vld_p3_q;
      if (vld_p3_q) begin
        left_q  <= flip(sat(pl_p4_x));
        right_q <= flip(sat(pr_p4_x));
        gain_q  <= gain_d;
      end
    end
  end

  assign left_o  = left_q;
  assign right_o = right_q;
  assign valid_o = vld_p4_q;

endmodule

// File: tb/tb_audio_stereo_mixer.sv
// Directed bench for audio_stereo_mixer: one instance without and one with the DC blocker,
// both fed the same stimulus.
module tb_audio_stereo_mixer;

  logic        clk = 1'b0;
  logic        res_n;
  logic        ce;
  logic [1:0]  mix;
  logic        mute;
  logic [15:0] left, right;
  logic [15:0] la, ra, lb, rb;
  logic        va, vb;

  int checks   = 0;
  int failures = 0;
  int lat;
  int seen;

  always #5 clk = ~clk;

  audio_stereo_mixer #(.W(16), .DCB_EN(0), .DCB_SHIFT(10), .RAMP_STEP(1)) dut_a (
    .clk_i(clk), .res_n_i(res_n), .ce_i(ce), .mix_i(mix), .mute_i(mute),
    .left_i(left), .right_i(right), .left_o(la), .right_o(ra), .valid_o(va));

  audio_stereo_mixer #(.W(16), .DCB_EN(1), .DCB_SHIFT(10), .RAMP_STEP(1)) dut_b (
    .clk_i(clk), .res_n_i(res_n), .ce_i(ce), .mix_i(mix), .mute_i(mute),
    .left_i(left), .right_i(right), .left_o(lb), .right_o(rb), .valid_o(vb));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One sample in, wait (bounded) for its valid_o; lat counts clock edges from ce.
  task automatic send(input logic [15:0] l, input logic [15:0] r, output int lat_o);
    @(posedge clk) #1;
    left = l; right = r; ce = 1'b1;
    @(posedge clk) #1;
    ce = 1'b0;
    lat_o = 1;
    while (!va && lat_o < 10) begin
      @(posedge clk) #1;
      lat_o++;
    end
    if (!va) begin
      checks++;
      failures++;
      $error("FAIL send_timeout observed=%0d expected=4", lat_o);
    end
  endtask

  initial begin
    res_n = 1'b1; ce = 1'b0; mix = 2'd0; mute = 1'b0;
    left = 16'h8000; right = 16'h8000;
    #2 res_n = 1'b0;
    #1;
    check("reset_left_a",  la, 16'h8000);
    check("reset_right_a", ra, 16'h8000);
    check("reset_valid_a", va, 1'b0);
    check("reset_left_b",  lb, 16'h8000);
    check("reset_valid_b", vb, 1'b0);
    repeat (3) @(posedge clk);
    #1 res_n = 1'b1;

    // Silence in, silence out; first valid exactly four edges after ce
    send(16'h8000, 16'h8000, lat);
    check("first_latency", lat, 4);
    check("silence_left_a", la, 16'h8000);
    check("silence_right_b", rb, 16'h8000);
    for (int i = 0; i < 3; i++) send(16'h8000, 16'h8000, lat);
    check("silence_left_b", lb, 16'h8000);

    // Let the fade-in reach full gain
    for (int i = 0; i < 256; i++) send(16'h8000, 16'h8000, lat);

    // DC blocker saturation on a full-scale step
    send(16'h0000, 16'h8000, lat);
    check("dcb_first_b", lb, 16'h0000);
    check("fullgain_a",  la, 16'h0000);
    send(16'h0000, 16'h8000, lat);
    check("dcb_decay_b", lb, 16'h0020);
    for (int i = 0; i < 98; i++) send(16'h0000, 16'h8000, lat);
    send(16'hFFFF, 16'h8000, lat);
    check("dcb_step_clamp", lb, 16'hFFFF);
    check("dcb_step_right", rb, 16'h8000);
    send(16'hFFFF, 16'h8000, lat);
    check("dcb_after_step", lb, 16'hFFE0);

    // Crossfeed levels
    mix = 2'd0; send(16'hC000, 16'h8000, lat);
    check("mix0_l", la, 16'hC000); check("mix0_r", ra, 16'h8000);
    mix = 2'd1; send(16'hC000, 16'h8000, lat);
    check("mix1_l", la, 16'hB800); check("mix1_r", ra, 16'h8800);
    mix = 2'd2; send(16'hC000, 16'h8000, lat);
    check("mix2_l", la, 16'hB000); check("mix2_r", ra, 16'h9000);
    mix = 2'd3; send(16'hC000, 16'h8000, lat);
    check("mix3_l", la, 16'hA000); check("mix3_r", ra, 16'hA000);

    // Back-to-back samples: valid on edges 4,5,6 after the first ce, in order
    mix = 2'd0;
    @(posedge clk) #1;
    left = 16'h9000; right = 16'h8000; ce = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk) #1;
      if (i == 1) left = 16'hA000;
      if (i == 2) left = 16'hB000;
      if (i == 3) ce = 1'b0;
      check($sformatf("b2b_valid_%0d", i), va, (i >= 4 && i <= 6) ? 1'b1 : 1'b0);
      if (i == 4) check("b2b_data0", la, 16'h9000);
      if (i == 5) check("b2b_data1", la, 16'hA000);
      if (i == 6) check("b2b_data2", la, 16'hB000);
      if (i == 8) check("b2b_hold",  la, 16'hB000);
    end

    // Mute ramp down then back up
    mute = 1'b1;
    for (int i = 0; i < 128; i++) send(16'hC000, 16'h8000, lat);
    send(16'hC000, 16'h8000, lat);
    check("mute_half", la, 16'hA000);
    for (int i = 0; i < 127; i++) send(16'hC000, 16'h8000, lat);
    send(16'hC000, 16'h8000, lat);
    check("mute_zero", la, 16'h8000);
    send(16'hC000, 16'h8000, lat);
    check("mute_stays", la, 16'h8000);
    mute = 1'b0;
    for (int i = 0; i < 255; i++) send(16'hC000, 16'h8000, lat);
    send(16'hC000, 16'h8000, lat);
    check("unmute_255", la, 16'hBFC0);
    send(16'hC000, 16'h8000, lat);
    check("unmute_full", la, 16'hC000);

    // Reset while three samples are in flight
    @(posedge clk) #1;
    left = 16'hC000; ce = 1'b1;
    repeat (3) @(posedge clk);
    #1 ce = 1'b0; res_n = 1'b0;
    #1;
    check("midreset_left",  la, 16'h8000);
    check("midreset_valid", va, 1'b0);
    @(posedge clk) #1 res_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk) #1;
      if (va) seen++;
    end
    check("midreset_no_valid", seen, 0);
    send(16'hC000, 16'h8000, lat);
    check("midreset_gain0", la, 16'h8000);
    send(16'hC000, 16'h8000, lat);
    check("midreset_gain1", la, 16'h8040);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
